// File: rtl/mult_pipe.sv
// mult_pipe: pipelined integer / carry-less multiplier.
//
// Computes RISC-V MUL/MULH/MULHU/MULHSU/MULW and, optionally, CLMUL/CLMULH/CLMULR.
// The arithmetic is evaluated when a request is accepted and written into stage 0.
// The following stages only carry the payload, so the result appears STAGES cycles
// after acceptance. A single stall (result valid but not taken) freezes every stage.
//
// Ports
//   clk_i             : clock, rising edge
//   rst_ni            : synchronous active-low reset
//   flush_i           : drop every in-flight op and any same-cycle request
//   mult_valid_i      : request valid
//   mult_ready_o      : request may be accepted (low while the output is stalled)
//   operation_i       : fu_op code
//   trans_id_i        : scoreboard tag travelling with the op
//   operand_a_i/b_i   : operands
//   result_valid_o    : result valid
//   result_ready_i    : consumer takes the result
//   result_o          : result, zero when result_valid_o is low
//   result_trans_id_o : tag of result_o, zero when result_valid_o is low

module mult_pipe #(
  parameter int unsigned XLEN          = 64,
  parameter int unsigned TRANS_ID_BITS = 3,
  parameter int unsigned STAGES        = 2,
  parameter bit          ENABLE_CLMUL  = 1'b1,
  parameter bit          IS_RV64       = 1'b1
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     flush_i,
  input  logic                     mult_valid_i,
  output logic                     mult_ready_o,
  input  logic [7:0]               operation_i,
  input  logic [TRANS_ID_BITS-1:0] trans_id_i,
  input  logic [XLEN-1:0]          operand_a_i,
  input  logic [XLEN-1:0]          operand_b_i,
  output logic                     result_valid_o,
  input  logic                     result_ready_i,
  output logic [XLEN-1:0]          result_o,
  output logic [TRANS_ID_BITS-1:0] result_trans_id_o
);

  localparam logic [7:0] OpMul    = 8'd83;
  localparam logic [7:0] OpMulh   = 8'd84;
  localparam logic [7:0] OpMulhu  = 8'd85;
  localparam logic [7:0] OpMulhsu = 8'd86;
  localparam logic [7:0] OpMulw   = 8'd87;
  localparam logic [7:0] OpClmul  = 8'd155;
  localparam logic [7:0] OpClmulh = 8'd156;
  localparam logic [7:0] OpClmulr = 8'd157;

  localparam int unsigned Last = STAGES - 1;

  // Sign-extend the low word to the full width (identity when XLEN is 32).
  function automatic logic [XLEN-1:0] sext_w(input logic [XLEN-1:0] v);
    logic [XLEN-1:0] r;
    for (int unsigned i = 0; i < XLEN; i++) begin
      r[i] = (i < 32) ? v[i] : v[31];
    end
    return r;
  endfunction

  // ---------------------------------------------------------------------------
  // Request decode
  // ---------------------------------------------------------------------------
  logic op_supported;
  logic stall;
  logic accept;

  always_comb begin
    op_supported = 1'b0;
    unique case (operation_i)
      OpMul, OpMulh, OpMulhu, OpMulhsu: op_supported = 1'b1;
      OpMulw:                           op_supported = IS_RV64;
      OpClmul, OpClmulh, OpClmulr:      op_supported = ENABLE_CLMUL;
      default:                          op_supported = 1'b0;
    endcase
  end

  assign stall        = result_valid_o & ~result_ready_i;
  assign mult_ready_o = ~stall;
  assign accept       = mult_valid_i & mult_ready_o & ~flush_i & op_supported;

  // ---------------------------------------------------------------------------
  // Integer product
  // ---------------------------------------------------------------------------
  // One (XLEN+1)x(XLEN+1) signed multiply covers all three signedness variants:
  // each operand gets an extra top bit that is either its sign or zero.
  logic                     sign_a;
  logic                     sign_b;
  logic signed [XLEN:0]     a_ext;
  logic signed [XLEN:0]     b_ext;
  logic signed [2*XLEN+1:0] prod;
  logic                     unused_prod;

  assign sign_a      = (operation_i == OpMulh) | (operation_i == OpMulhsu);
  assign sign_b      = (operation_i == OpMulh);
  assign a_ext       = $signed({sign_a & operand_a_i[XLEN-1], operand_a_i});
  assign b_ext       = $signed({sign_b & operand_b_i[XLEN-1], operand_b_i});
  assign prod        = a_ext * b_ext;
  assign unused_prod = ^prod[2*XLEN+1:2*XLEN];

  // ---------------------------------------------------------------------------
  // Carry-less product
  // ---------------------------------------------------------------------------
  logic [2*XLEN-1:0] clp;

  if (ENABLE_CLMUL) begin : gen_clmul
    always_comb begin
      clp = '0;
      for (int unsigned i = 0; i < XLEN; i++) begin
        if (operand_b_i[i]) begin
          clp = clp ^ ({{XLEN{1'b0}}, operand_a_i} << i);
        end
      end
    end
  end else begin : gen_no_clmul
    assign clp = '0;
  end

  // ---------------------------------------------------------------------------
  // Result selection at entry. MULW keeps the raw low word here; the sign
  // extension is applied at the output using the op carried down the pipe.
  // ---------------------------------------------------------------------------
  logic [XLEN-1:0] res_raw;

  always_comb begin
    res_raw = '0;
    unique case (operation_i)
      OpMul, OpMulw:                res_raw = prod[XLEN-1:0];
      OpMulh, OpMulhu, OpMulhsu:    res_raw = prod[2*XLEN-1:XLEN];
      OpClmul:                      res_raw = clp[XLEN-1:0];
      OpClmulh:                     res_raw = clp[2*XLEN-1:XLEN];
      OpClmulr:                     res_raw = clp[2*XLEN-2:XLEN-1];
      default:                      res_raw = '0;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Pipeline stages
  // ---------------------------------------------------------------------------
  logic [STAGES-1:0]        valid_q, valid_d;
  logic [TRANS_ID_BITS-1:0] tag_q  [STAGES];
  logic [TRANS_ID_BITS-1:0] tag_d  [STAGES];
  logic [7:0]               op_q   [STAGES];
  logic [7:0]               op_d   [STAGES];
  logic [XLEN-1:0]          data_q [STAGES];
  logic [XLEN-1:0]          data_d [STAGES];

  always_comb begin
    valid_d = valid_q;
    tag_d   = tag_q;
    op_d    = op_q;
    data_d  = data_q;

    if (!stall) begin
      // Bubbles enter with a zero payload so idle stages stay quiet.
      valid_d[0] = accept;
      tag_d[0]   = accept ? trans_id_i  : '0;
      op_d[0]    = accept ? operation_i : '0;
      data_d[0]  = accept ? res_raw     : '0;
      for (int unsigned s = 1; s < STAGES; s++) begin
        valid_d[s] = valid_q[s-1];
        tag_d[s]   = tag_q[s-1];
        op_d[s]    = op_q[s-1];
        data_d[s]  = data_q[s-1];
      end
    end

    // Flush wins over both the stall hold and a same-cycle accept.
    if (flush_i) begin
      valid_d = '0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      valid_q <= '0;
      for (int unsigned s = 0; s < STAGES; s++) begin
        tag_q[s]  <= '0;
        op_q[s]   <= '0;
        data_q[s] <= '0;
      end
    end else begin
      valid_q <= valid_d;
      tag_q   <= tag_d;
      op_q    <= op_d;
      data_q  <= data_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs, driven from the last stage only
  // ---------------------------------------------------------------------------
  always_comb begin
    result_valid_o    = valid_q[Last];
    result_o          = '0;
    result_trans_id_o = '0;
    if (valid_q[Last]) begin
      result_trans_id_o = tag_q[Last];
      result_o          = (op_q[Last] == OpMulw) ? sext_w(data_q[Last]) : data_q[Last];
    end
  end

endmodule

// File: doc/mult_pipe.md
MULT_PIPE -- requirements
Module: mult_pipe

Interface
REQ-001 Parameter XLEN, default 64, operand and result width (32 or 64).
REQ-002 Parameter TRANS_ID_BITS, default 3, transaction-ID width.
REQ-003 Parameter STAGES, default 2, pipeline depth / latency in cycles (1..4).
REQ-004 Parameter ENABLE_CLMUL, default 1, carry-less ops present when 1.
REQ-005 Parameter IS_RV64, default 1, MULW supported when 1.
REQ-006 Port clk_i, input, 1, sole clock, rising edge.
REQ-007 Port rst_ni, input, 1, reset; synchronous and active-low.
REQ-008 Port flush_i, input, 1, kill all in-flight ops.
REQ-009 Port mult_valid_i, input, 1, request valid.
REQ-010 Port mult_ready_o, output, 1, request accepted when high with mult_valid_i.
REQ-011 Port operation_i, input, 8, fu_op code: MUL=83, MULH=84, MULHU=85, MULHSU=86, MULW=87, CLMUL=155, CLMULH=156, CLMULR=157.
REQ-012 Port trans_id_i, input, TRANS_ID_BITS, scoreboard tag.
REQ-013 Port operand_a_i / operand_b_i, input, XLEN each, operands.
REQ-014 Port result_valid_o, output, 1, result valid.
REQ-015 Port result_ready_i, input, 1, consumer accepts result.
REQ-016 Port result_o, output, XLEN, result.
REQ-017 Port result_trans_id_o, output, TRANS_ID_BITS, tag of result_o.

Function
REQ-018 Accept = mult_valid_i & mult_ready_o & ~flush_i & op supported; unsupported ops (incl. clmul when ENABLE_CLMUL=0, MULW when IS_RV64=0) are dropped, no result.
REQ-019 Each stage holds valid, trans_id, op, data; accepted op appears on result_* exactly STAGES cycles later absent stalls.
REQ-020 Stall = result_valid_o & ~result_ready_i; during stall every stage holds; mult_ready_o = ~stall.
REQ-021 Ops retire in issue order; one op per cycle throughput when unstalled.
REQ-022 result_o, result_trans_id_o stable while result_valid_o high and stalled.
REQ-023 MUL: low XLEN of a*b; MULH: high XLEN of signed*signed; MULHU: unsigned*unsigned; MULHSU: signed a * unsigned b.
REQ-024 MULW: sign-extend bits [31:0] of a*b to 64.
REQ-025 Carry-less product P (2*XLEN bits): CLMUL = P[XLEN-1:0]; CLMULH = P[2*XLEN-1:XLEN]; CLMULR = P[2*XLEN-2:XLEN-1].
REQ-026 flush_i clears all stage valids at next edge, overrides stall and same-cycle accept; result_valid_o low the cycle after flush.
REQ-027 result_o is 0 whenever result_valid_o is low.
REQ-028 Valid/tag path fully registered; no combinational path mult_valid_i -> result_valid_o.

Reset
REQ-029 rst_ni low at clock edge clears all stage valids, tags, ops, data to 0.
REQ-030 During and after reset: result_valid_o=0, result_o=0, result_trans_id_o=0, mult_ready_o=1.
REQ-031 Reset mid-operation discards in-flight ops; none emerge afterwards.

Verification
REQ-032 STAGES=2: MULH a=0xFFFF_FFFF_FFFF_FFFF, b=2, tag 5 -> result_o=0xFFFF_FFFF_FFFF_FFFF, tag 5, cycle+2.
REQ-033 MULW a=0x7FFF_FFFF, b=2 -> 0xFFFF_FFFF_FFFF_FFFE; MULHU a=b=0xFFFF_FFFF_FFFF_FFFF -> 0xFFFF_FFFF_FFFF_FFFE.
REQ-034 CLMUL a=3,b=3 -> 5; CLMULH a=b=0x8000_0000_0000_0000 -> 0x4000_0000_0000_0000; CLMULR same -> 0x8000_0000_0000_0000.
REQ-035 Back-to-back tags 1,2,3 with result_ready_i low 3 cycles -> mult_ready_o=0, tag 1 held, then 1,2,3 in order, no loss/duplication.
REQ-036 flush_i with 2 in flight plus same-cycle request -> no results emerge; next request after flush returns normally.
REQ-037 rst_ni low with ops in flight -> all outputs 0, mult_ready_o=1, no late results.
